// File: rtl/sr_pulse_driver.sv
// Set/reset latch pulse driver: turns level requests into timed, exclusive S/R pulses
// followed by an idle gap. Optional fb_q readback check is enabled by SR_READBACK_CHECK_EN.
module sr_pulse_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic S,
  output logic R,
  output logic q_exp,
  output logic q_known,
  output logic busy,
  input  logic fb_q,
  output logic err
);

  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          qexp_q, qexp_d;
  logic          qknown_q, qknown_d;
  logic          busy_q, busy_d;
  logic          ret_idle;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    s_d      = s_q;
    r_d      = r_q;
    qexp_d   = qexp_q;
    qknown_d = qknown_q;
    ret_idle = 1'b0;
    case (state_q)
      IDLE: begin
        // A request matching a known latch level needs no pulse.
        if (req_valid && !(qknown_q && (req_level == qexp_q))) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          level_d = req_level;
          s_d     = req_level;
          r_d     = ~req_level;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          s_d      = 1'b0;
          r_d      = 1'b0;
          qexp_d   = level_q;
          qknown_d = 1'b1;
          if (GAP_W == 0) begin
            state_d  = IDLE;
            ret_idle = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          ret_idle = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      qexp_q   <= 1'b0;
      qknown_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      s_q      <= s_d;
      r_q      <= r_d;
      qexp_q   <= qexp_d;
      qknown_q <= qknown_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign S         = s_q;
  assign R         = r_q;
  assign q_exp     = qexp_q;
  assign q_known   = qknown_q;
  assign busy      = busy_q;

`ifdef SR_READBACK_CHECK_EN
  logic err_q;

  // level_q is compared rather than qexp_q since with GAP_W==0 both update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ret_idle && (fb_q != level_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = fb_q ^ ret_idle;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: a default instance (PULSE_W=4, GAP_W=2) and a
// fast instance (PULSE_W=1, GAP_W=0); outputs are sampled on the falling edge.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_level = 1'b0, fb_q = 1'b0;
  logic req_ready, S, R, q_exp, q_known, busy, err;
  logic req_valid2 = 1'b0, req_level2 = 1'b0, fb_q2 = 1'b0;
  logic req_ready2, S2, R2, q_exp2, q_known2, busy2, err2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_pulse_driver #(.PULSE_W(4), .GAP_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .S(S), .R(R), .q_exp(q_exp), .q_known(q_known),
    .busy(busy), .fb_q(fb_q), .err(err)
  );

  sr_pulse_driver #(.PULSE_W(1), .GAP_W(0)) dut_fast (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_level(req_level2),
    .req_ready(req_ready2), .S(S2), .R(R2), .q_exp(q_exp2), .q_known(q_known2),
    .busy(busy2), .fb_q(fb_q2), .err(err2)
  );

  // S and R must never be high together on either instance.
  always @(negedge clk) begin
    vectors++;
    if ((S & R) !== 1'b0 || (S2 & R2) !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sr_exclusive S=%b R=%b S2=%b R2=%b required no overlap", S, R, S2, R2);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    req_valid = 1'b0;
    req_level = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    obs = {S, R, busy, req_ready, q_exp, q_known, err};
    vectors++;
    if (obs !== 7'b0001000) begin
      miscompares++;
      $display("[TB] FAIL reset_state got=%b want=%b", obs, 7'b0001000);
    end
    rst = 1'b0;
  endtask

  task automatic test_set_pulse();
    logic [5:0] obs, exp_v;
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_v = {(c <= 4), 1'b0, (c <= 6), (c == 7), (c >= 5), (c >= 5)};
      obs = {S, R, busy, req_ready, q_exp, q_known};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL set_pulse cycle %0d got=%b want=%b", c, obs, exp_v);
      end
      if (c < 7) tick();
    end
  endtask

  task automatic test_redundant();
    logic [5:0] obs;
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      obs = {S, R, busy, req_ready, q_exp, q_known};
      vectors++;
      if (obs !== 6'b000111) begin
        miscompares++;
        $display("[TB] FAIL redundant cycle %0d got=%b want=%b", c, obs, 6'b000111);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic seq [3] = '{1'b1, 1'b0, 1'b1};
    int idx = 0;
    logic acc;
    logic [1:0] obs, exp_v;
    pulse_reset();
    req_valid = 1'b1;
    req_level = seq[0];
    for (int c = 1; c <= 21; c++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) req_level = seq[idx];
        else req_valid = 1'b0;
      end
      exp_v = {((c >= 1 && c <= 4) || (c >= 15 && c <= 18)), (c >= 8 && c <= 11)};
      obs = {S, R};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d SR got=%b want=%b", c, obs, exp_v);
      end
    end
    vectors++;
    if (idx != 3 || q_exp !== 1'b1 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_done accepted=%0d q_exp=%b ready=%b want 3/1/1", idx, q_exp, req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    logic [4:0] obs;
    logic [5:0] fin;
    pulse_reset();
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if (S !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_pulse_s got=%b want=1", S);
    end
    #2 rst = 1'b1;
    #1;
    obs = {S, R, busy, req_ready, q_known};
    vectors++;
    if (obs !== 5'b00010) begin
      miscompares++;
      $display("[TB] FAIL async_reset got=%b want=%b", obs, 5'b00010);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    vectors++;
    if ({S, R} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL unknown_r_pulse SR got=%b want=01", {S, R});
    end
    repeat (6) tick();
    fin = {S, R, busy, req_ready, q_exp, q_known};
    vectors++;
    if (fin !== 6'b000101) begin
      miscompares++;
      $display("[TB] FAIL unknown_r_done got=%b want=%b", fin, 6'b000101);
    end
  endtask

  task automatic test_fast();
    logic seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int idx = 0;
    logic acc;
    logic [1:0] obs, exp_v;
    pulse_reset();
    req_valid2 = 1'b1;
    req_level2 = seq[0];
    for (int c = 1; c <= 8; c++) begin
      acc = req_valid2 && req_ready2;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) req_level2 = seq[idx];
        else req_valid2 = 1'b0;
      end
      exp_v = {(c == 1 || c == 5), (c == 3 || c == 7)};
      obs = {S2, R2};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL fast cycle %0d SR got=%b want=%b", c, obs, exp_v);
      end
    end
    vectors++;
    if (idx != 4 || q_exp2 !== 1'b0 || q_known2 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fast_done accepted=%0d q_exp=%b q_known=%b want 4/0/1", idx, q_exp2, q_known2);
    end
    req_valid2 = 1'b0;
  endtask

  task automatic test_readback();
`ifdef SR_READBACK_CHECK_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif
    pulse_reset();
    fb_q = 1'b0;
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_early got=%b want=0", err);
    end
    tick();
    vectors++;
    if (err !== exp_err || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_set got=%b ready=%b want=%b/1", err, req_ready, exp_err);
    end
    req_valid = 1'b1;
    req_level = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    vectors++;
    if (err !== exp_err || q_exp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_sticky got=%b q_exp=%b want=%b/0", err, q_exp, exp_err);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_clear got=%b want=0", err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_pulse();
    test_redundant();
    test_back_to_back();
    test_reset_mid_pulse();
    test_fast();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
